// File: rtl/synch_ram_pkg.sv
// Shared types and helpers for the burst-capable synchronous RAM.
// Parity storage is enabled by defining SYNCH_RAM_PARITY_EN.
package synch_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST_RD = 2'd1,
    BURST_WR = 2'd2
  } state_t;

  // Even parity over a zero-extended word (words up to 64 bits).
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/synch_ram_core.sv
// Storage array with one write port and a registered read port.
// Ports: we/re/addr/wdata in; rdata/rvalid/perr registered out.
module synch_ram_core
  import synch_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              perr
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef SYNCH_RAM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wword;
  logic [MW-1:0] rword;

`ifdef SYNCH_RAM_PARITY_EN
  assign wword = {parity(64'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  assign rword = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      perr   <= 1'b0;
    end else begin
      rvalid <= re;
      perr   <= 1'b0;
      if (re) begin
        rdata <= rword[DATA_W-1:0];
`ifdef SYNCH_RAM_PARITY_EN
        perr  <= rword[DATA_W] ^
                 parity(64'(rword[DATA_W-1:0]));
`endif
      end
    end
  end

endmodule

// File: rtl/synch_ram_burst.sv
// Chip-selected RAM slave with single accesses and wrapping bursts.
// Optional parity via SYNCH_RAM_PARITY_EN; parityErr is 0 otherwise.
module synch_ram_burst
  import synch_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipsel,
  input  logic              writeEn,
  input  logic              readEn,
  input  logic              burstStart,
  input  logic [LEN_W-1:0]  burstLen,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] busIn,
  output logic [DATA_W-1:0] busOut,
  output logic              readValid,
  output logic              busy,
  output logic              burstDone,
  output logic              parityErr
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;

  logic              idle_acc;
  logic              rd_beat;
  logic              wr_beat;
  logic              beat;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;

  assign idle_acc = (state == IDLE) && chipsel && !burstStart;
  assign rd_beat  = (state == BURST_RD) && chipsel;
  assign wr_beat  = (state == BURST_WR) && chipsel && writeEn;
  assign beat     = rd_beat || wr_beat;

  // A write wins over a simultaneous single read.
  always_comb begin
    we   = 1'b0;
    re   = 1'b0;
    addr = addrIn;
    unique case (1'b1)
      idle_acc: begin
        we = writeEn;
        re = readEn && !writeEn;
      end
      rd_beat: begin
        re   = 1'b1;
        addr = ptr;
      end
      wr_beat: begin
        we   = 1'b1;
        addr = ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      burstDone <= 1'b0;
    end else begin
      burstDone <= 1'b0;
      case (state)
        IDLE: begin
          if (chipsel && burstStart) begin
            ptr   <= addrIn;
            cnt   <= burstLen;
            busy  <= 1'b1;
            state <= writeEn ? BURST_WR : BURST_RD;
          end
        end
        BURST_RD, BURST_WR: begin
          if (!chipsel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (beat) begin
            ptr <= ptr + 1'b1;
            if (cnt == '0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              burstDone <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  synch_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .re     (re),
    .addr   (addr),
    .wdata  (busIn),
    .rdata  (busOut),
    .rvalid (readValid),
    .perr   (parityErr)
  );

endmodule

// File: tb/tb_synch_ram_burst.sv
// Self-checking bench for synch_ram_burst: directed cases plus
// randomized traffic against a behavioural memory model.
module tb_synch_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chipsel = 1'b0;
  logic       writeEn = 1'b0;
  logic       readEn = 1'b0;
  logic       burstStart = 1'b0;
  logic [3:0] burstLen = '0;
  logic [7:0] addrIn = '0;
  logic [7:0] busIn = '0;
  logic [7:0] busOut;
  logic       readValid;
  logic       busy;
  logic       burstDone;
  logic       parityErr;

  int checks = 0;
  int errors = 0;

  synch_ram_burst u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chipsel    (chipsel),
    .writeEn    (writeEn),
    .readEn     (readEn),
    .burstStart (burstStart),
    .burstLen   (burstLen),
    .addrIn     (addrIn),
    .busIn      (busIn),
    .busOut     (busOut),
    .readValid  (readValid),
    .busy       (busy),
    .burstDone  (burstDone),
    .parityErr  (parityErr)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 read burst, 2 write burst.
  logic [7:0] mm [256];
  bit         bad [256];
  int         m_mode = 0;
  int         m_ptr = 0;
  int         m_left = 0;
  logic       e_rv = 0;
  logic [7:0] e_bo = 0;
  logic       e_done = 0;
  logic       e_busy = 0;
  logic       e_pe = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; e_rv = 0; e_bo = 0;
      e_done = 0; e_busy = 0; e_pe = 0;
    end else begin
      e_rv = 0; e_done = 0; e_pe = 0;
      if (m_mode == 0) begin
        if (chipsel && burstStart) begin
          m_mode = writeEn ? 2 : 1;
          m_ptr  = int'(addrIn);
          m_left = int'(burstLen) + 1;
        end else if (chipsel && writeEn) begin
          mm[addrIn]  = busIn;
          bad[addrIn] = 0;
        end else if (chipsel && readEn) begin
          e_rv = 1;
          e_bo = mm[addrIn];
          e_pe = bad[addrIn];
        end
      end else if (!chipsel) begin
        m_mode = 0;
      end else if (m_mode == 1 || writeEn) begin
        if (m_mode == 1) begin
          e_rv = 1;
          e_bo = mm[m_ptr];
          e_pe = bad[m_ptr];
        end else begin
          mm[m_ptr]  = busIn;
          bad[m_ptr] = 0;
        end
        m_ptr  = (m_ptr + 1) % 256;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 0;
          e_done = 1;
        end
      end
      e_busy = (m_mode != 0);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_readValid", 32'(readValid), 32'(e_rv));
      chk("m_busOut",    32'(busOut),    32'(e_bo));
      chk("m_busy",      32'(busy),      32'(e_busy));
      chk("m_burstDone", 32'(burstDone), 32'(e_done));
      chk("m_parityErr", 32'(parityErr), 32'(e_pe));
    end
  end

  // Apply inputs at a falling edge, return after the next one.
  task automatic drive(input logic cs, input logic we,
                       input logic re, input logic bs,
                       input logic [3:0] len,
                       input logic [7:0] a,
                       input logic [7:0] d);
    chipsel = cs; writeEn = we; readEn = re;
    burstStart = bs; burstLen = len; addrIn = a; busIn = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mm[i] = 0;
      bad[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busOut", 32'(busOut), 0);
    chk("rst_readValid", 32'(readValid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_burstDone", 32'(burstDone), 0);
    chk("rst_parityErr", 32'(parityErr), 0);
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    for (int i = 0; i < 256; i++)
      drive(1, 1, 0, 0, 0, 8'(i), 8'($urandom));

    drive(1, 1, 0, 0, 0, 8'h00, 8'hBE);
    drive(1, 1, 0, 0, 0, 8'hEE, 8'hA1);
    drive(1, 0, 1, 0, 0, 8'h00, 0);
    chk("rd00_valid", 32'(readValid), 1);
    chk("rd00_data", 32'(busOut), 32'h BE);
    drive(1, 0, 1, 0, 0, 8'hEE, 0);
    chk("rdEE_valid", 32'(readValid), 1);
    chk("rdEE_data", 32'(busOut), 32'hA1);

    drive(1, 1, 1, 0, 0, 8'h10, 8'h55);
    chk("wr_rd_novalid", 32'(readValid), 0);
    idle();
    drive(1, 0, 1, 0, 0, 8'h10, 0);
    chk("rd10_data", 32'(busOut), 32'h55);

    drive(1, 1, 0, 1, 3, 8'hFE, 0);
    chk("wb_busy", 32'(busy), 1);
    drive(1, 1, 0, 0, 0, 0, 8'd1);
    drive(1, 1, 0, 0, 0, 0, 8'd2);
    drive(1, 0, 0, 0, 0, 0, 8'd9);
    chk("wb_stall_busy", 32'(busy), 1);
    drive(1, 1, 0, 0, 0, 0, 8'd3);
    chk("wb_nodone", 32'(burstDone), 0);
    drive(1, 1, 0, 0, 0, 0, 8'd4);
    chk("wb_done", 32'(burstDone), 1);
    chk("wb_idle", 32'(busy), 0);

    drive(1, 0, 0, 1, 3, 8'hFE, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1'(i), 0, 0, 8'h33, 0);
      chk("rb_valid", 32'(readValid), 1);
      chk("rb_data", 32'(busOut), 32'(i + 1));
      chk("rb_done", 32'(burstDone), 32'(i == 3));
    end
    chk("rb_busy_drop", 32'(busy), 0);
    idle();
    chk("rb_after", 32'(readValid), 0);

    drive(1, 0, 0, 1, 3, 8'h20, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(readValid), 0);
    chk("abort_done", 32'(burstDone), 0);
    idle();

    drive(1, 0, 0, 1, 7, 8'h40, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_valid", 32'(readValid), 0);
    chk("rstmid_busOut", 32'(busOut), 0);
    chk("rstmid_done", 32'(burstDone), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

`ifdef SYNCH_RAM_PARITY_EN
    u_dut.u_core.mem[0][0] = ~u_dut.u_core.mem[0][0];
    mm[0][0] = ~mm[0][0];
    bad[0] = 1;
    drive(1, 0, 1, 0, 0, 8'h00, 0);
    chk("par_err", 32'(parityErr), 1);
    chk("par_valid", 32'(readValid), 1);
`else
    drive(1, 0, 1, 0, 0, 8'h00, 0);
    chk("par_off", 32'(parityErr), 0);
    chk("par_valid", 32'(readValid), 1);
`endif

    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 24) != 0,
            1'($urandom), 1'($urandom),
            $urandom_range(0, 5) == 0,
            4'($urandom), 8'($urandom), 8'($urandom));
    end
    repeat (20) idle();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_ram_burst.md
# synch_ram_burst

Parametrised synchronous single-port RAM that generalises the byte-wide `synch_ram`. It adds configurable data and address widths, registered reads with a valid strobe, and an auto-incrementing burst engine for read and write bursts of up to 2^LEN_W beats, with address wrap-around. It sits on the local data bus as a chip-selected memory slave, behind the bus decoder.

## Interface
- DATA_W, 8: data word width in bits
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words
- LEN_W, 4: burst length field width; bursts are 1..2**LEN_W beats
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- chipsel  in  1  block select; all requests are ignored while low
- writeEn  in  1  write request (single access), burst direction select, write-beat strobe
- readEn  in  1  read request (single access)
- burstStart  in  1  start a burst; sampled only in IDLE
- burstLen  in  LEN_W  number of beats minus one
- addrIn  in  ADDR_W  single-access address, or burst base address
- busIn  in  DATA_W  write data
- busOut  out  DATA_W  registered read data; holds its last value when no read completes
- readValid  out  1  one-cycle strobe marking new busOut data
- busy  out  1  high whenever the state is not IDLE
- burstDone  out  1  one-cycle pulse on the final beat of a burst
- parityErr  out  1  parity mismatch on the current readValid beat (see Configuration)

## Operation
- States: IDLE, BURST_RD, BURST_WR. Memory contents are not reset.
- **IDLE, single accesses** (chipsel=1, burstStart=0):
  - writeEn=1: write busIn to mem[addrIn].
  - readEn=1 and writeEn=0: read mem[addrIn].
  - writeEn and readEn both high: only the write is performed; readValid stays 0.
- **IDLE, burst start** (chipsel=1, burstStart=1):
  - Capture ptr=addrIn and cnt=burstLen.
  - writeEn=1 → BURST_WR; otherwise → BURST_RD.
  - No access occurs in the start cycle. readEn is ignored.
- **BURST_RD**:
  - Every cycle: read mem[ptr], then ptr=ptr+1 mod DEPTH.
  - While cnt>0: cnt=cnt-1.
  - On the cnt=0 beat: pulse burstDone and return to IDLE.
- **BURST_WR**:
  - Each cycle with writeEn=1: write busIn to mem[ptr] and advance ptr/cnt as in BURST_RD.
  - writeEn=0 stalls the burst; no write and no advance.
  - On the final written beat: pulse burstDone and return to IDLE.
- **While busy**: single-access requests and burstStart are ignored.
- **Abort**: chipsel=0 during a burst → IDLE on the next edge. No burstDone; already-written words remain.
- **Wrap-around**: ptr wraps from DEPTH-1 to 0.

## Timing
- Reset values: busOut=0, readValid=0, busy=0, burstDone=0, parityErr=0, state=IDLE, ptr=0, cnt=0.
- Read latency is 1 cycle. A read sampled at edge N drives busOut and readValid=1 after edge N, valid until edge N+1.
- Write data is visible to a read sampled at edge N+1 or later. Write-then-read of the same address on consecutive cycles returns the new data.
- Burst of L beats accepted at edge N:
  - Read: beats at edges N+1..N+L. readValid high after each of those edges; burstDone coincides with the last readValid; busy high after edges N..N+L-1.
  - Write: same timing, plus one cycle per stall.
- rst_n low mid-burst: immediate return to IDLE with all outputs at reset values.

## Configuration
- SYNCH_RAM_PARITY_EN defined:
  - Each stored word carries an even-parity bit computed from busIn on write.
  - On every read beat, parityErr = stored parity XOR recomputed parity, registered alongside readValid.
- Undefined: no parity storage; parityErr is tied to 0.

## Structure
- Package synch_ram_pkg holds:
  - state enum (IDLE, BURST_RD, BURST_WR)
  - default DATA_W/ADDR_W/LEN_W constants
  - parity function
- Sub-module synch_ram_core contains the storage array `mem` (DEPTH × DATA_W, plus the parity bit when enabled) with one write port and a registered read port.
- The top level contains the FSM, ptr/cnt counters and strobes.

## Test plan
- Reset, then single writes of 8'hBE to 8'h00 and 8'hA1 to 8'hEE; read both → busOut=BE then A1, each one cycle after the request with readValid=1.
- writeEn=readEn=1 at 8'h10 with busIn=8'h55 → readValid stays 0; a later read of 8'h10 returns 8'h55.
- Write burst: base 8'hFE, burstLen=3, data 1,2,3,4 with one writeEn stall → mem[FE]=1, mem[FF]=2, mem[00]=3, mem[01]=4 (wrap); burstDone after 5 beat cycles.
- Read burst: base 8'hFE, burstLen=3 → readValid high 4 consecutive cycles with 1,2,3,4; burstDone on the 4th; busy drops after it; readEn pulses during the burst are ignored.
- Drop chipsel after 2 beats of a 4-beat read burst → IDLE next edge, no burstDone. Separately, assert rst_n=0 mid-burst → all outputs 0 immediately.
- With SYNCH_RAM_PARITY_EN: flip one data bit of mem[8'h00] hierarchically, then read 8'h00 → parityErr=1 with readValid. Without the macro, parityErr=0.
